// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result/flags and bit-serial shifts.
// Build option: define ALU_MUL_EN to add the WIDTH-cycle shift-add multiplier on op 9.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             err
);
   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
      OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_SRA = 4'd8, OP_MUL = 4'd9
   } op_t;

   state_t           state;
   logic [3:0]       kind;
   logic [WIDTH-1:0] sh;
   logic [CNT_W-1:0] cnt;
   logic [SH_W-1:0]  amt;
   logic             is_shift;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   dif;
   logic [WIDTH-1:0] r_y;
   logic             r_c;
   logic             r_v;
   logic             r_e;

   logic [WIDTH-1:0] sh_next;
   logic             sh_out;
   logic [WIDTH-1:0] fin_y;
   logic             fin_c;

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_next;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH:0]     madd;
`endif

   assign in_ready = (state == IDLE) && !rst;
   assign amt      = b[SH_W-1:0];
   assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);

   // Result of every op that completes in the accept cycle (incl. zero-amount shifts).
   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      dif = {1'b0, a} - {1'b0, b};
      r_y = '0;
      r_c = 1'b0;
      r_v = 1'b0;
      r_e = 1'b0;
      case (op)
         OP_ADD: begin
            r_y = sum[WIDTH-1:0];
            r_c = sum[WIDTH];
            r_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            r_y = dif[WIDTH-1:0];
            r_c = ~dif[WIDTH];
            r_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: r_y = a & b;
         OP_OR:  r_y = a | b;
         OP_XOR: r_y = a ^ b;
         OP_NOT: r_y = ~a;
         OP_SHL, OP_SHR, OP_SRA: r_y = a;
`ifdef ALU_MUL_EN
         OP_MUL: r_y = '0;
`endif
         default: r_e = 1'b1;
      endcase
   end

   always_comb begin
      sh_next = sh;
      sh_out  = 1'b0;
      case (kind)
         OP_SHL: begin
            sh_next = {sh[WIDTH-2:0], 1'b0};
            sh_out  = sh[WIDTH-1];
         end
         OP_SHR: begin
            sh_next = {1'b0, sh[WIDTH-1:1]};
            sh_out  = sh[0];
         end
         OP_SRA: begin
            sh_next = {sh[WIDTH-1], sh[WIDTH-1:1]};
            sh_out  = sh[0];
         end
         default: ;
      endcase
   end

`ifdef ALU_MUL_EN
   // Low half of prod starts as the multiplier and is consumed LSB-first.
   always_comb begin
      madd      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_next = {madd, prod[WIDTH-1:1]};
   end
`endif

   always_comb begin
      fin_y = sh_next;
      fin_c = sh_out;
`ifdef ALU_MUL_EN
      if (kind == OP_MUL) begin
         fin_y = prod_next[WIDTH-1:0];
         fin_c = |prod_next[2*WIDTH-1:WIDTH];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         kind      <= '0;
         sh        <= '0;
         cnt       <= '0;
         y         <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
`ifdef ALU_MUL_EN
         prod      <= '0;
         mcand     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  kind <= op;
                  if (is_shift && (amt != '0)) begin
                     sh    <= a;
                     cnt   <= CNT_W'(amt);
                     state <= BUSY;
                  end
`ifdef ALU_MUL_EN
                  else if (op == OP_MUL) begin
                     mcand <= a;
                     prod  <= {{WIDTH{1'b0}}, b};
                     cnt   <= CNT_W'(WIDTH);
                     state <= BUSY;
                  end
`endif
                  else begin
                     y         <= r_y;
                     carry     <= r_c;
                     zero      <= (r_y == '0);
                     neg       <= r_y[WIDTH-1];
                     ovf       <= r_v;
                     err       <= r_e;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
               sh  <= sh_next;
`ifdef ALU_MUL_EN
               if (kind == OP_MUL) prod <= prod_next;
`endif
               if (cnt == CNT_W'(1)) begin
                  y         <= fin_y;
                  carry     <= fin_c;
                  zero      <= (fin_y == '0);
                  neg       <= fin_y[WIDTH-1];
                  ovf       <= 1'b0;
                  err       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
